// File: rtl/noc_pkg.sv
// Shared NoC router types and constants.
// Flit width, downstream buffer depth and port indices.
package noc_pkg;

  localparam int FLIT_W    = 32;
  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = 3;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [2:0] {
    PORT_N,
    PORT_S,
    PORT_W,
    PORT_E,
    PORT_L
  } port_e;

endpackage

// File: rtl/credit_counter.sv
// Saturating downstream credit counter.
// Holds 0..DEPTH, reports nonzero and rejected (overflowing) returns.
module credit_counter
  import noc_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int CNT_W = noc_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             nonzero_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             dec;

  assign full      = (cnt == FULL);
  assign nonzero_o = (cnt != '0);
  assign count_o   = cnt;
  assign dec       = dec_i && nonzero_o;
  assign ovf_o     = inc_i && full && !dec;

  // a send and a return in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= FULL;
    end else if (dec && !inc_i) begin
      cnt <= cnt - 1'b1;
    end else if (inc_i && !dec && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/n_out_credit_tracker.sv
// North output back end: grant decode, flit forwarding, credits.
// Feeds credit_avail and change_order back to the north arbiter.
module n_out_credit_tracker
  import noc_pkg::*;
#(
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int BUF_DEPTH = noc_pkg::BUF_DEPTH,
  parameter int CNT_W     = noc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant_s_i,
  input  logic              grant_w_i,
  input  logic              grant_e_i,
  input  logic              grant_l_i,
  input  logic [FLIT_W-1:0] flit_s_i,
  input  logic [FLIT_W-1:0] flit_w_i,
  input  logic [FLIT_W-1:0] flit_e_i,
  input  logic [FLIT_W-1:0] flit_l_i,
  input  logic              credit_return_i,
  output logic [FLIT_W-1:0] flit_o,
  output logic              flit_valid_o,
  output logic              credit_avail_o,
  output logic              change_order_o,
  output logic [CNT_W-1:0]  credit_count_o,
  output logic              credit_err_o
);

  logic [3:0]        grants;
  logic              any_grant;
  logic              one_grant;
  logic              send;
  logic              nonzero;
  logic              ovf;
  logic              err_evt;
  logic [FLIT_W-1:0] sel_flit;

  assign grants    = {grant_l_i, grant_e_i, grant_w_i, grant_s_i};
  assign any_grant = |grants;
  assign one_grant = $onehot(grants);
  assign send      = one_grant && nonzero;

  // and-or mux; only consumed when exactly one grant is high
  assign sel_flit = ({FLIT_W{grant_s_i}} & flit_s_i)
                  | ({FLIT_W{grant_w_i}} & flit_w_i)
                  | ({FLIT_W{grant_e_i}} & flit_e_i)
                  | ({FLIT_W{grant_l_i}} & flit_l_i);

  assign err_evt = (any_grant && !one_grant)
                 || (any_grant && !nonzero)
                 || ovf;

  credit_counter #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .dec_i     (send),
    .inc_i     (credit_return_i),
    .count_o   (credit_count_o),
    .nonzero_o (nonzero),
    .ovf_o     (ovf)
  );

  assign credit_avail_o = nonzero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flit_o         <= '0;
      flit_valid_o   <= 1'b0;
      change_order_o <= 1'b0;
      credit_err_o   <= 1'b0;
    end else begin
      flit_valid_o   <= send;
      change_order_o <= send;
      if (send) flit_o <= sel_flit;
      if (err_evt) credit_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_n_out_credit_tracker.sv
// Randomized and directed check of n_out_credit_tracker
// against an integer-level credit model.
module tb_n_out_credit_tracker;

  localparam int FW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          grant_s_i, grant_w_i, grant_e_i, grant_l_i;
  logic [FW-1:0] flit_s_i, flit_w_i, flit_e_i, flit_l_i;
  logic          credit_return_i;
  logic [FW-1:0] flit_o;
  logic          flit_valid_o;
  logic          credit_avail_o;
  logic          change_order_o;
  logic [CW-1:0] credit_count_o;
  logic          credit_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  int            m_cnt;
  bit            m_err;
  bit            m_valid;
  logic [FW-1:0] m_flit;

  n_out_credit_tracker #(
    .FLIT_W    (FW),
    .BUF_DEPTH (DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .grant_s_i       (grant_s_i),
    .grant_w_i       (grant_w_i),
    .grant_e_i       (grant_e_i),
    .grant_l_i       (grant_l_i),
    .flit_s_i        (flit_s_i),
    .flit_w_i        (flit_w_i),
    .flit_e_i        (flit_e_i),
    .flit_l_i        (flit_l_i),
    .credit_return_i (credit_return_i),
    .flit_o          (flit_o),
    .flit_valid_o    (flit_valid_o),
    .credit_avail_o  (credit_avail_o),
    .change_order_o  (change_order_o),
    .credit_count_o  (credit_count_o),
    .credit_err_o    (credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle: g = {l,e,w,s}; rst_n low applies reset
  task automatic step(input logic [3:0] g, input bit ret,
                      input bit rst_n);
    logic [FW-1:0] fl [4];
    int n;
    bit snd;
    @(negedge clk);
    for (int i = 0; i < 4; i++) fl[i] = $urandom;
    flit_s_i = fl[0];
    flit_w_i = fl[1];
    flit_e_i = fl[2];
    flit_l_i = fl[3];
    {grant_l_i, grant_e_i, grant_w_i, grant_s_i} = g;
    credit_return_i = ret;
    reset = rst_n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(g[i]);
    if (!rst_n) begin
      m_cnt = DEPTH; m_err = 0; m_valid = 0; m_flit = '0;
    end else begin
      snd = (n == 1) && (m_cnt > 0);
      if (n >= 2 || (n >= 1 && m_cnt == 0)) m_err = 1;
      if (ret && m_cnt == DEPTH && !snd) m_err = 1;
      m_cnt = m_cnt - int'(snd) + int'(ret);
      if (m_cnt > DEPTH) m_cnt = DEPTH;
      m_valid = snd;
      if (snd)
        for (int i = 0; i < 4; i++) if (g[i]) m_flit = fl[i];
    end
    @(posedge clk);
    #1;
    check("count", 64'(credit_count_o), 64'(m_cnt));
    check("valid", 64'(flit_valid_o), 64'(m_valid));
    check("chg_order", 64'(change_order_o), 64'(m_valid));
    check("avail", 64'(credit_avail_o), 64'(m_cnt != 0));
    check("err", 64'(credit_err_o), 64'(m_err));
    check("flit", 64'(flit_o), 64'(m_flit));
  endtask

  initial begin
    logic [3:0] g;
    int r;
    int pulses;
    reset = 1'b0;
    {grant_l_i, grant_e_i, grant_w_i, grant_s_i} = '0;
    credit_return_i = 1'b0;
    flit_s_i = '0; flit_w_i = '0; flit_e_i = '0; flit_l_i = '0;
    m_cnt = DEPTH; m_err = 0; m_valid = 0; m_flit = '0;

    // reset state
    step(4'b0000, 0, 0);
    check("t1_cnt", 64'(credit_count_o), 64'(4));
    check("t1_avail", 64'(credit_avail_o), 64'(1));

    // four west sends drain all credits
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'b0010, 0, 1);
      pulses += int'(change_order_o);
      check("t2_cnt", 64'(credit_count_o), 64'(3 - i));
      check("t2_flit", 64'(flit_o), 64'(flit_w_i));
    end
    check("t2_pulses", 64'(pulses), 64'(4));
    check("t2_avail", 64'(credit_avail_o), 64'(0));

    // grant at zero credits
    step(4'b0001, 0, 1);
    check("t3_valid", 64'(flit_valid_o), 64'(0));
    check("t3_err", 64'(credit_err_o), 64'(1));

    // count=2, send and return together
    step(4'b0000, 0, 0);
    step(4'b0001, 0, 1);
    step(4'b0001, 0, 1);
    step(4'b0100, 1, 1);
    check("t4_valid", 64'(flit_valid_o), 64'(1));
    check("t4_cnt", 64'(credit_count_o), 64'(2));

    // overflow return then double grant
    step(4'b0000, 0, 0);
    step(4'b0000, 1, 1);
    check("t5_cnt", 64'(credit_count_o), 64'(4));
    check("t5_err", 64'(credit_err_o), 64'(1));
    step(4'b1001, 0, 1);
    check("t5_nosend", 64'(flit_valid_o), 64'(0));

    // reset with a flit in flight
    step(4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) step(4'b1000, 0, 1);
    step(4'b0000, 0, 0);
    check("t6_cnt", 64'(credit_count_o), 64'(4));
    check("t6_valid", 64'(flit_valid_o), 64'(0));
    check("t6_err", 64'(credit_err_o), 64'(0));

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) g = 4'b0001 << $urandom_range(0, 3);
      else if (r < 85) g = 4'b0000;
      else g = 4'($urandom);
      step(g, ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) >= 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
